tmds_align_ctrl: RTL and testbench

TMDS_ALIGN_CTRL -- requirements
Module: tmds_align_ctrl

---
 rtl/tmds_pkg.sv | 11 +
 rtl/tmds_win_cnt.sv | 37 +++
 rtl/tmds_align_ctrl.sv | 58 +++++
 tb/tb_tmds_align_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/tmds_pkg.sv
// tmds_pkg: TMDS control tokens and word-alignment state encoding, shared across the TMDS receive path
package tmds_pkg;
   localparam logic [9:0] CTL_TOK0 = 10'h354;
   localparam logic [9:0] CTL_TOK1 = 10'h0AB;
   localparam logic [9:0] CTL_TOK2 = 10'h154;
   localparam logic [9:0] CTL_TOK3 = 10'h2AB;
   typedef enum logic [1:0] {ST_SEARCH, ST_SLIP, ST_SETTLE, ST_LOCKED} align_state_t;
   function automatic logic is_ctl(input logic [9:0] w);
      return w == CTL_TOK0 || w == CTL_TOK1 || w == CTL_TOK2 || w == CTL_TOK3;
   endfunction
endpackage

// File: rtl/tmds_win_cnt.sv
// tmds_win_cnt: per-window word/error/control-token accounting with window-end and early-abort detection
module tmds_win_cnt
   import tmds_pkg::*;
#(
   parameter int WINDOW  = 4096,
   parameter int ERR_MAX = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       stb,
   input  logic [9:0] enc,
   input  logic       valid,
   output logic       win_end,
   output logic       win_good
);
   logic [15:0] words, errs, words_n, errs_n;
   logic ctl, ctl_n;
   always_comb begin
      words_n  = words + 16'(stb);
      errs_n   = errs + 16'(stb && !valid);
      ctl_n    = ctl | (stb && valid && is_ctl(enc));
      win_end  = en && stb && (words_n == 16'(WINDOW) || errs_n > 16'(ERR_MAX));
      win_good = errs_n <= 16'(ERR_MAX) && ctl_n;
   end
   always_ff @(posedge clk) begin
      if (rst || !en || win_end) begin
         words <= '0;
         errs  <= '0;
         ctl   <= 1'b0;
      end else begin
         words <= words_n;
         errs  <= errs_n;
         ctl   <= ctl_n;
      end
   end
endmodule

// File: rtl/tmds_align_ctrl.sv
// tmds_align_ctrl: TMDS word-alignment controller issuing bitslips until control tokens lock the channel
module tmds_align_ctrl
   import tmds_pkg::*;
#(
   parameter int WINDOW     = 4096,
   parameter int ERR_MAX    = 4,
   parameter int SETTLE     = 16,
   parameter int LOCK_WIN   = 4,
   parameter int UNLOCK_WIN = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stb,
   input  logic [9:0] enc,
   input  logic       valid,
   output logic       bitslip,
   output logic       locked,
   output logic [3:0] slip_cnt
);
   align_state_t state, nxt;
   logic [15:0] good_cnt, bad_cnt;
   logic [7:0] settle_cnt;
   logic win_end, win_good, acct;
   assign acct = state == ST_SEARCH || state == ST_LOCKED;
   tmds_win_cnt #(.WINDOW(WINDOW), .ERR_MAX(ERR_MAX)) u_win (
      .clk(clk), .rst(rst), .en(acct), .stb(stb), .enc(enc), .valid(valid),
      .win_end(win_end), .win_good(win_good)
   );
   always_comb begin
      nxt = state;
      case (state)
         ST_SEARCH: if (win_end) nxt = !win_good ? ST_SLIP :
                                       good_cnt + 16'd1 == 16'(LOCK_WIN) ? ST_LOCKED : ST_SEARCH;
         ST_LOCKED: if (win_end && !win_good && bad_cnt + 16'd1 == 16'(UNLOCK_WIN)) nxt = ST_SLIP;
         ST_SLIP:   nxt = ST_SETTLE;
         default:   if (settle_cnt == 8'(SETTLE - 1)) nxt = ST_SEARCH;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_SEARCH;
         bitslip    <= 1'b0;
         locked     <= 1'b0;
         slip_cnt   <= '0;
         good_cnt   <= '0;
         bad_cnt    <= '0;
         settle_cnt <= '0;
      end else begin
         state      <= nxt;
         bitslip    <= nxt == ST_SLIP;
         locked     <= nxt == ST_LOCKED;
         if (nxt == ST_SLIP) slip_cnt <= slip_cnt == 4'd9 ? 4'd0 : slip_cnt + 4'd1;
         good_cnt   <= state == ST_SEARCH ? good_cnt + 16'(win_end && win_good) : '0;
         bad_cnt    <= state != ST_LOCKED ? '0 : !win_end ? bad_cnt : win_good ? '0 : bad_cnt + 16'd1;
         settle_cnt <= state == ST_SETTLE ? settle_cnt + 8'd1 : '0;
      end
   end
endmodule

// File: tb/tb_tmds_align_ctrl.sv
// tb_tmds_align_ctrl: random stimulus against a cycle-count reference model, scoreboard-checked outputs
module tb_tmds_align_ctrl;
   localparam int WINDOW = 64, ERR_MAX = 4, SETTLE = 8, LOCK_WIN = 4, UNLOCK_WIN = 2;
   logic clk = 0, rst = 1, stb = 0, valid = 0;
   logic [9:0] enc = '0;
   logic bitslip, locked;
   logic [3:0] slip_cnt;
   logic [9:0] toks [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};
   logic [5:0] exp_q [$];
   int checks = 0, passes = 0, cyc = 0;
   int m_quiet = 0, m_words = 0, m_errs = 0, m_goods = 0, m_bads = 0, m_sc = 0;
   bit m_ctl = 0, m_lk = 0, m_bs = 0;

   tmds_align_ctrl #(.WINDOW(WINDOW), .ERR_MAX(ERR_MAX), .SETTLE(SETTLE),
                     .LOCK_WIN(LOCK_WIN), .UNLOCK_WIN(UNLOCK_WIN)) dut (
      .clk(clk), .rst(rst), .stb(stb), .enc(enc), .valid(valid),
      .bitslip(bitslip), .locked(locked), .slip_cnt(slip_cnt)
   );

   always #5 clk = ~clk;

   function automatic bit is_tok(logic [9:0] w);
      return w == 10'h354 || w == 10'h0AB || w == 10'h154 || w == 10'h2AB;
   endfunction

   // reference model: predicts outputs for the next cycle from this cycle's inputs
   always @(posedge clk) begin
      bit slip, good;
      slip = 0;
      m_bs = 0;
      cyc++;
      if (rst) begin
         m_quiet = 0; m_words = 0; m_errs = 0; m_ctl = 0;
         m_goods = 0; m_bads = 0; m_lk = 0; m_sc = 0;
      end else if (m_quiet > 0) begin
         m_quiet--;
         m_words = 0; m_errs = 0; m_ctl = 0; m_goods = 0;
      end else if (stb) begin
         m_words++;
         if (!valid) m_errs++;
         if (valid && is_tok(enc)) m_ctl = 1;
         if (m_words == WINDOW || m_errs > ERR_MAX) begin
            good = m_errs <= ERR_MAX && m_ctl;
            m_words = 0; m_errs = 0; m_ctl = 0;
            if (!m_lk) begin
               if (!good) slip = 1;
               else if (++m_goods == LOCK_WIN) begin m_lk = 1; m_goods = 0; m_bads = 0; end
            end else if (good) m_bads = 0;
            else if (++m_bads == UNLOCK_WIN) begin m_lk = 0; slip = 1; end
         end
      end
      if (slip) begin
         m_bs = 1; m_sc = (m_sc + 1) % 10; m_quiet = SETTLE + 1; m_goods = 0; m_bads = 0;
      end
      exp_q.push_back({m_bs, m_lk, 4'(m_sc)});
   end

   always @(negedge clk) begin
      logic [5:0] e, a;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {bitslip, locked, slip_cnt};
         checks++;
         if (a === e) passes++;
         else $display("FAIL outputs cycle %0d: got bitslip=%0b locked=%0b slip_cnt=%0d, want bitslip=%0b locked=%0b slip_cnt=%0d",
                       cyc, a[5], a[4], a[3:0], e[5], e[4], e[3:0]);
      end
   end

   task automatic do_reset(int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 1; stb = 0; valid = 0;
      end
   endtask

   // stb_div>1 strobes every stb_div-th cycle; stb_div==0 strobes at random
   task automatic run(int n, int stb_div, int err_pct, int tok_pct);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rst = 0;
         stb = stb_div == 0 ? 1'($urandom_range(1)) : stb_div <= 1 ? 1'b1 : (i % stb_div == 0);
         valid = $urandom_range(99) >= err_pct;
         if ($urandom_range(99) < tok_pct) enc = toks[$urandom_range(3)];
         else begin
            enc = 10'($urandom);
            if (is_tok(enc)) enc ^= 10'h001;
         end
      end
   endtask

   initial begin
      do_reset(3);
      checks++;
      if ({bitslip, locked, slip_cnt} === 6'd0) passes++;
      else $display("FAIL reset state: bitslip=%0b locked=%0b slip_cnt=%0d", bitslip, locked, slip_cnt);
      run(300, 1, 0, 10);
      run(64, 1, 0, 0);
      run(200, 1, 0, 10);
      run(150, 1, 0, 0);
      fork
         run(400, 1, 100, 0);
         begin
            int t;
            t = 0;
            while (bitslip !== 1'b1 && t < 50) begin
               @(negedge clk);
               t++;
            end
            checks++;
            if (bitslip === 1'b1) passes++;
            else $display("FAIL wait for bitslip expired after %0d cycles", t);
         end
      join
      run(700, 1, 0, 0);
      do_reset(2);
      run(36, 1, 100, 0);
      do_reset(1);
      run(900, 3, 0, 10);
      run(2000, 1, 3, 5);
      for (int k = 0; k < 6; k++) begin
         run($urandom_range(50, 600), $urandom_range(0, 3), $urandom_range(0, 10), $urandom_range(0, 15));
         do_reset($urandom_range(1, 3));
      end
      run(300, 0, 1, 10);
      @(negedge clk);
      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
